layer_blit_sequencer: RTL and testbench

- Per-frame scheduler that drives the `layer` select of the game-state block and walks layers 0..NUM_LAYERS-1 in order.
- For each layer it latches the returned VRAM source rectangle and framebuffer destination, then issues one copy request to the blitter over a valid/ready handshake.
- It waits for the blitter's completion, then advances to the next layer.
- At the end of a frame it flips the double-buffer select and pulses `frame_done`. It sits between the game-state block, the blitter and the video timing block.

---
 rtl/game_pkg.sv | 28 ++
 rtl/sat_counter8.sv | 22 ++
 rtl/layer_blit_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_layer_blit_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types for the game-state, layer sequencer and blitter blocks
package game_pkg;

  localparam int NUM_LAYERS = 14;
  localparam int COORD_W    = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } seq_state_t;

  typedef struct packed {
    logic [COORD_W-1:0] inicio_X;
    logic [COORD_W-1:0] inicio_Y;
    logic [COORD_W-1:0] final_X;
    logic [COORD_W-1:0] final_Y;
  } rect_t;

  typedef struct packed {
    logic [COORD_W-1:0] X;
    logic [COORD_W-1:0] Y;
  } point_t;

endpackage

// File: rtl/sat_counter8.sv
// rtl/sat_counter8.sv - 8-bit event counter that sticks at 255
module sat_counter8 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_inc,
  output logic [7:0] o_count
);

  logic [7:0] r_count;

  // count enabled events, holding at all-ones once reached
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= 8'd0;
    end else if (i_inc && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/layer_blit_sequencer.sv
// rtl/layer_blit_sequencer.sv - per-frame walker issuing one blit request per layer
module layer_blit_sequencer #(
  parameter int NUM_LAYERS = game_pkg::NUM_LAYERS,
  parameter int LAYER_W    = 32,
  parameter int TIMEOUT    = 65535,
  parameter int CW         = game_pkg::COORD_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_frame_start,
  output logic [LAYER_W-1:0] o_layer,
  input  logic [CW-1:0]      i_vram_inicio_X,
  input  logic [CW-1:0]      i_vram_inicio_Y,
  input  logic [CW-1:0]      i_vram_final_X,
  input  logic [CW-1:0]      i_vram_final_Y,
  input  logic [CW-1:0]      i_FB_X,
  input  logic [CW-1:0]      i_FB_Y,
  output logic               o_blit_valid,
  input  logic               i_blit_ready,
  output logic [CW-1:0]      o_blit_src_X,
  output logic [CW-1:0]      o_blit_src_Y,
  output logic [CW-1:0]      o_blit_dst_X,
  output logic [CW-1:0]      o_blit_dst_Y,
  output logic [CW-1:0]      o_blit_w,
  output logic [CW-1:0]      o_blit_h,
  input  logic               i_blit_done,
  output logic               o_fb_sel,
  output logic               o_frame_done,
  output logic               o_busy,
  output logic [7:0]         o_overrun_cnt,
  output logic [7:0]         o_timeout_cnt
);

  import game_pkg::*;

  localparam int                 TW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]      TIMER_MAX  = TW'(TIMEOUT - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  seq_state_t         r_state, w_next;
  logic [LAYER_W-1:0] r_layer;
  point_t             r_src, r_dst;
  logic [CW-1:0]      r_w, r_h;
  logic               r_valid, r_fb_sel, r_frame_done;
  logic [TW-1:0]      r_timer;

  rect_t  w_rect;
  point_t w_fb;
  logic   w_degen, w_overrun;
  logic   w_latch, w_set_valid, w_clr_valid, w_timer_clr, w_timer_inc;
  logic   w_timeout, w_inc_layer, w_clr_layer, w_frame_done;

  assign w_rect  = {i_vram_inicio_X, i_vram_inicio_Y, i_vram_final_X, i_vram_final_Y};
  assign w_fb    = {i_FB_X, i_FB_Y};
  // a rectangle whose end lies before its start has nothing to copy
  assign w_degen = (w_rect.final_X < w_rect.inicio_X) || (w_rect.final_Y < w_rect.inicio_Y);
  // vsync arriving while a frame is still in flight (DONE included) is dropped
  assign w_overrun = i_frame_start && (r_state != S_IDLE);

  // state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // next-state and per-state datapath controls
  always_comb begin
    w_next       = r_state;
    w_latch      = 1'b0;
    w_set_valid  = 1'b0;
    w_clr_valid  = 1'b0;
    w_timer_clr  = 1'b0;
    w_timer_inc  = 1'b0;
    w_timeout    = 1'b0;
    w_inc_layer  = 1'b0;
    w_clr_layer  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_frame_start) begin
          w_clr_layer = 1'b1;
          w_next      = S_LATCH;
        end
      end
      S_LATCH: begin
        w_latch = 1'b1;
        if (w_degen) begin
          w_next = S_NEXT;
        end else begin
          w_set_valid = 1'b1;
          w_next      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_blit_ready) begin
          w_clr_valid = 1'b1;
          w_timer_clr = 1'b1;
          w_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_blit_done) begin
          w_next = S_NEXT;
        end else if (r_timer == TIMER_MAX) begin
          w_timeout = 1'b1;
          w_next    = S_NEXT;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      S_NEXT: begin
        if (r_layer == LAST_LAYER) begin
          w_next = S_DONE;
        end else begin
          w_inc_layer = 1'b1;
          w_next      = S_LATCH;
        end
      end
      S_DONE: begin
        w_frame_done = 1'b1;
        w_clr_layer  = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // layer index, latched request fields, handshake, WAIT timer and buffer flip
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_layer      <= '0;
      r_src        <= '0;
      r_dst        <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_valid      <= 1'b0;
      r_timer      <= '0;
      r_fb_sel     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_done;
      if (w_clr_layer)      r_layer <= '0;
      else if (w_inc_layer) r_layer <= r_layer + 1'b1;
      if (w_latch) begin
        r_src <= {w_rect.inicio_X, w_rect.inicio_Y};
        r_dst <= w_fb;
        r_w   <= w_rect.final_X - w_rect.inicio_X;
        r_h   <= w_rect.final_Y - w_rect.inicio_Y;
      end
      if (w_set_valid)      r_valid <= 1'b1;
      else if (w_clr_valid) r_valid <= 1'b0;
      if (w_timer_clr)      r_timer <= '0;
      else if (w_timer_inc) r_timer <= r_timer + 1'b1;
      if (w_frame_done)     r_fb_sel <= ~r_fb_sel;
    end
  end

  sat_counter8 u_overrun_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_overrun),
    .o_count (o_overrun_cnt)
  );

  sat_counter8 u_timeout_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_inc   (w_timeout),
    .o_count (o_timeout_cnt)
  );

  assign o_layer      = r_layer;
  assign o_blit_valid = r_valid;
  assign o_blit_src_X = r_src.X;
  assign o_blit_src_Y = r_src.Y;
  assign o_blit_dst_X = r_dst.X;
  assign o_blit_dst_Y = r_dst.Y;
  assign o_blit_w     = r_w;
  assign o_blit_h     = r_h;
  assign o_fb_sel     = r_fb_sel;
  assign o_frame_done = r_frame_done;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_layer_blit_sequencer.sv
// tb/tb_layer_blit_sequencer.sv - directed self-checking bench for layer_blit_sequencer
module tb_layer_blit_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic [31:0] layer;
  logic [9:0]  vix, viy, vfx, vfy, fbx, fby;
  logic        blit_valid;
  logic        blit_ready = 1'b1;
  logic        blit_done = 1'b0;
  logic [9:0]  src_x, src_y, dst_x, dst_y, bw, bh;
  logic        fb_sel, frame_done, busy;
  logic [7:0]  overrun_cnt, timeout_cnt;
  logic [59:0] w_geom;

  int n_checks = 0;
  int n_pass   = 0;
  int degen_layer = -1;
  int stall_layer = -1;
  int stall_left  = 0;
  int stall_seen  = 0;
  int hang_layer  = -1;
  logic pending = 1'b0;
  logic [59:0] snap;
  int log_layer[$];
  logic [59:0] log_geom[$];
  int lat;
  int cnt;

  always #5 clk = ~clk;

  layer_blit_sequencer #(.TIMEOUT(16)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_frame_start   (frame_start),
    .o_layer         (layer),
    .i_vram_inicio_X (vix),
    .i_vram_inicio_Y (viy),
    .i_vram_final_X  (vfx),
    .i_vram_final_Y  (vfy),
    .i_FB_X          (fbx),
    .i_FB_Y          (fby),
    .o_blit_valid    (blit_valid),
    .i_blit_ready    (blit_ready),
    .o_blit_src_X    (src_x),
    .o_blit_src_Y    (src_y),
    .o_blit_dst_X    (dst_x),
    .o_blit_dst_Y    (dst_y),
    .o_blit_w        (bw),
    .o_blit_h        (bh),
    .i_blit_done     (blit_done),
    .o_fb_sel        (fb_sel),
    .o_frame_done    (frame_done),
    .o_busy          (busy),
    .o_overrun_cnt   (overrun_cnt),
    .o_timeout_cnt   (timeout_cnt)
  );

  assign w_geom = {src_x, src_y, dst_x, dst_y, bw, bh};

  // game-state asset table: rectangle and destination as functions of layer
  always_comb begin
    vix = 10'(layer * 3);
    viy = 10'(layer * 2 + 1);
    vfx = 10'(layer * 4 + 4);
    vfy = 10'(layer * 2 + 6);
    fbx = 10'(layer + 100);
    fby = 10'(layer * 7 + 200);
    if (degen_layer >= 0 && layer == 32'(degen_layer)) begin
      vix = 10'd10;
      vfx = 10'd5;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // blitter model: ready with optional stall, done one cycle after acceptance
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pending    = 1'b0;
        blit_done  = 1'b0;
        blit_ready = 1'b1;
      end else begin
        blit_done  = pending;
        pending    = 1'b0;
        blit_ready = 1'b1;
        if (blit_valid && stall_layer >= 0 && int'(layer) == stall_layer && stall_left > 0) begin
          blit_ready = 1'b0;
          if (stall_seen == 0) snap = w_geom;
          else chk("stall_hold", 64'(w_geom), 64'(snap));
          stall_seen++;
          stall_left--;
        end
        if (blit_valid && blit_ready) begin
          log_layer.push_back(int'(layer));
          log_geom.push_back(w_geom);
          if (int'(layer) != hang_layer) pending = 1'b1;
        end
      end
    end
  end

  task automatic run_frame(output int l);
    log_layer.delete();
    log_geom.delete();
    stall_seen = 0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    l = 1;
    while (!frame_done && l < 3000) begin
      @(negedge clk);
      l++;
    end
    if (!frame_done) chk("frame_done_seen", 64'd0, 64'd1);
  endtask

  function automatic int count_layer(input int which);
    int c = 0;
    foreach (log_layer[i]) if (log_layer[i] == which) c++;
    return c;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [59:0] exp4;
    exp4 = {10'd12, 10'd9, 10'd104, 10'd228, 10'd8, 10'd5};
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(blit_valid), 64'd0);
    chk("rst_layer", 64'(layer), 64'd0);
    chk("rst_fb_sel", 64'(fb_sel), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_overrun", 64'(overrun_cnt), 64'd0);
    chk("rst_timeout", 64'(timeout_cnt), 64'd0);
    chk("rst_geom", 64'(w_geom), 64'd0);
    rst = 1'b0;

    // plain frame, zero-latency blitter: 1 + 14*4 + 1
    run_frame(lat);
    chk("f1_latency", 64'(lat), 64'd58);
    chk("f1_count", 64'(log_layer.size()), 64'd14);
    for (int i = 0; i < 14; i++)
      if (log_layer.size() > i) chk("f1_order", 64'(log_layer[i]), 64'(i));
    if (log_geom.size() > 4) chk("f1_layer4_geom", 64'(log_geom[4]), 64'(exp4));
    chk("f1_fb_sel", 64'(fb_sel), 64'd1);
    chk("f1_layer_back", 64'(layer), 64'd0);
    @(negedge clk);
    chk("f1_idle", 64'(busy), 64'd0);
    chk("f1_done_pulse", 64'(frame_done), 64'd0);

    // degenerate rectangle on layer 3 is skipped
    degen_layer = 3;
    run_frame(lat);
    chk("f2_latency", 64'(lat), 64'd56);
    chk("f2_count", 64'(log_layer.size()), 64'd13);
    chk("f2_no_layer3", 64'(count_layer(3)), 64'd0);
    if (log_layer.size() > 3) chk("f2_after3", 64'(log_layer[3]), 64'd4);
    chk("f2_fb_sel", 64'(fb_sel), 64'd0);
    degen_layer = -1;

    // blitter back-pressure on layer 2 for 7 cycles
    stall_layer = 2;
    stall_left  = 7;
    run_frame(lat);
    chk("f3_stall_cycles", 64'(stall_seen), 64'd7);
    chk("f3_latency", 64'(lat), 64'd65);
    chk("f3_one_accept", 64'(count_layer(2)), 64'd1);
    chk("f3_count", 64'(log_layer.size()), 64'd14);
    stall_layer = -1;

    // no completion on layer 5: abandoned after 16 WAIT cycles
    hang_layer = 5;
    run_frame(lat);
    chk("f4_latency", 64'(lat), 64'd73);
    chk("f4_timeout_cnt", 64'(timeout_cnt), 64'd1);
    if (log_layer.size() > 6) chk("f4_layer6", 64'(log_layer[6]), 64'd6);
    chk("f4_count", 64'(log_layer.size()), 64'd14);
    hang_layer = -1;

    // 300 extra vsyncs while a long frame is in flight
    stall_layer = 1;
    stall_left  = 700;
    stall_seen  = 0;
    log_layer.delete();
    log_geom.delete();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      if (i == 99) chk("f5_overrun_100", 64'(overrun_cnt), 64'd100);
    end
    chk("f5_overrun_sat", 64'(overrun_cnt), 64'd255);
    cnt = 0;
    while (!frame_done && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    chk("f5_frame_done", 64'(frame_done), 64'd1);
    chk("f5_count", 64'(log_layer.size()), 64'd14);
    if (log_layer.size() > 13) chk("f5_last", 64'(log_layer[13]), 64'd13);
    chk("f5_fb_sel", 64'(fb_sel), 64'd1);
    chk("f5_timeout_kept", 64'(timeout_cnt), 64'd1);
    stall_layer = -1;

    // reset while waiting on layer 7
    hang_layer = 7;
    log_layer.delete();
    log_geom.delete();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cnt = 0;
    while (log_layer.size() < 8 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    @(negedge clk);
    chk("f6_pre_layer", 64'(layer), 64'd7);
    chk("f6_pre_wait", 64'({busy, blit_valid}), 64'b10);
    #1 rst = 1'b1;
    #1;
    chk("f6_rst_busy", 64'(busy), 64'd0);
    chk("f6_rst_valid", 64'(blit_valid), 64'd0);
    chk("f6_rst_layer", 64'(layer), 64'd0);
    chk("f6_rst_fb_sel", 64'(fb_sel), 64'd0);
    chk("f6_rst_counters", 64'({overrun_cnt, timeout_cnt}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hang_layer = -1;
    run_frame(lat);
    chk("f7_latency", 64'(lat), 64'd58);
    if (log_layer.size() > 0) chk("f7_first", 64'(log_layer[0]), 64'd0);
    chk("f7_count", 64'(log_layer.size()), 64'd14);
    chk("f7_fb_sel", 64'(fb_sel), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
